led_chase_sched: RTL and testbench

LED_CHASE_SCHED -- requirements
Module: led_chase_sched

---
 rtl/led_chase_sched.sv | 206 ++++++++++++++++++++
 tb/tb_led_chase_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/led_chase_sched.sv
// led_chase_sched: five-channel LED chase scheduler.
// One channel at a time is selected for DWELL clocks. While a channel is
// selected, its LED toggles with that channel's half-period HPn. Modes are
// forward, reverse, ping-pong, and all-blink. i_stop lets the current dwell
// finish before the block returns to IDLE.
// Optional feature: define LED_CHASE_SCHED_PAUSE_EN to add the i_pause input,
// which freezes the running schedule while it is high.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_stop     start request / graceful stop request
//   i_pause             (LED_CHASE_SCHED_PAUSE_EN only) freeze while running
//   i_mode[1:0]         00 fwd, 01 rev, 10 ping-pong, 11 all-blink
//   o_led[4:0]          LED drive, bit n = channel n
//   o_ch[2:0]           selected channel index
//   o_busy              high in RUN and STOPPING
//   o_sweep             one-cycle pulse at end of each full sweep
module led_chase_sched #(
  parameter int unsigned HP0   = 50,
  parameter int unsigned HP1   = 25,
  parameter int unsigned HP2   = 17,
  parameter int unsigned HP3   = 10,
  parameter int unsigned HP4   = 5,
  parameter int unsigned DWELL = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_stop,
`ifdef LED_CHASE_SCHED_PAUSE_EN
  input  logic       i_pause,
`endif
  input  logic [1:0] i_mode,
  output logic [4:0] o_led,
  output logic [2:0] o_ch,
  output logic       o_busy,
  output logic       o_sweep
);

  localparam int unsigned TW = 16;
  localparam int unsigned DW = 20;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  localparam logic [1:0] M_FWD  = 2'b00;
  localparam logic [1:0] M_REV  = 2'b01;
  localparam logic [1:0] M_PING = 2'b10;
  localparam logic [1:0] M_ALL  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t        state, state_n;
  logic [1:0]    mode, mode_n;
  logic [2:0]    ch, ch_n, adv_ch;
  logic [4:0]    led, led_n;
  logic [TW-1:0] tog, tog_n;
  logic [DW-1:0] dwell, dwell_n;
  logic          dir_dn, dir_dn_n, adv_dir;
  logic          adv_sweep, sweep_n, busy_n;
  logic          pause;

`ifdef LED_CHASE_SCHED_PAUSE_EN
  assign pause = i_pause;
`else
  assign pause = 1'b0;
`endif

  // Last toggle-counter value for a channel (half-period minus one)
  function automatic logic [TW-1:0] hp_last(input logic [2:0] c);
    case (c)
      3'd0:    hp_last = TW'(HP0 - 1);
      3'd1:    hp_last = TW'(HP1 - 1);
      3'd2:    hp_last = TW'(HP2 - 1);
      3'd3:    hp_last = TW'(HP3 - 1);
      default: hp_last = TW'(HP4 - 1);
    endcase
  endfunction

  // LED pattern at the start of a dwell: all-blink lights every LED
  function automatic logic [4:0] led_init(input logic [1:0] m, input logic [2:0] c);
    led_init = (m == M_ALL) ? 5'h1f : (5'b00001 << c);
  endfunction

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      mode    <= M_FWD;
      ch      <= '0;
      led     <= '0;
      tog     <= '0;
      dwell   <= '0;
      dir_dn  <= 1'b0;
      o_busy  <= 1'b0;
      o_sweep <= 1'b0;
    end else begin
      state   <= state_n;
      mode    <= mode_n;
      ch      <= ch_n;
      led     <= led_n;
      tog     <= tog_n;
      dwell   <= dwell_n;
      dir_dn  <= dir_dn_n;
      o_busy  <= busy_n;
      o_sweep <= sweep_n;
    end
  end

  assign o_led = led;
  assign o_ch  = ch;

  // Next-state, channel advance and LED toggle logic
  always_comb begin
    state_n   = state;
    mode_n    = mode;
    ch_n      = ch;
    led_n     = led;
    tog_n     = tog;
    dwell_n   = dwell;
    dir_dn_n  = dir_dn;
    sweep_n   = 1'b0;
    adv_ch    = ch;
    adv_dir   = dir_dn;
    adv_sweep = 1'b0;

    // Channel that follows the current one at dwell expiry
    case (mode)
      M_FWD: begin
        adv_ch    = (ch == 3'd4) ? 3'd0 : ch + 3'd1;
        adv_sweep = (ch == 3'd4);
      end
      M_REV: begin
        adv_ch    = (ch == 3'd0) ? 3'd4 : ch - 3'd1;
        adv_sweep = (ch == 3'd0);
      end
      M_PING: begin
        if (!dir_dn) begin
          if (ch == 3'd4) begin
            adv_ch  = 3'd3;
            adv_dir = 1'b1;
          end else begin
            adv_ch  = ch + 3'd1;
          end
        end else begin
          if (ch == 3'd0) begin
            adv_ch  = 3'd1;
            adv_dir = 1'b0;
          end else begin
            adv_ch  = ch - 3'd1;
          end
          adv_sweep = (ch == 3'd1);
        end
      end
      default: begin
        adv_ch    = 3'd0;
        adv_sweep = 1'b1;
      end
    endcase

    case (state)
      IDLE: begin
        led_n = '0;
        if (i_start && !i_stop) begin
          state_n  = RUN;
          mode_n   = i_mode;
          ch_n     = (i_mode == M_REV) ? 3'd4 : 3'd0;
          led_n    = led_init(i_mode, (i_mode == M_REV) ? 3'd4 : 3'd0);
          tog_n    = '0;
          dwell_n  = '0;
          dir_dn_n = 1'b0;
        end
      end
      default: begin
        if (!pause) begin
          if (dwell == DWELL_LAST) begin
            sweep_n = adv_sweep;
            tog_n   = '0;
            dwell_n = '0;
            if (state == STOPPING) begin
              // Stop lands on the advance edge; o_ch keeps the last channel
              state_n = IDLE;
              led_n   = '0;
            end else begin
              ch_n     = adv_ch;
              dir_dn_n = adv_dir;
              led_n    = led_init(mode, adv_ch);
            end
          end else begin
            dwell_n = dwell + DW'(1);
            // All-blink always sits on channel 0, so it toggles with HP0
            if (tog == hp_last(ch)) begin
              tog_n = '0;
              led_n = (mode == M_ALL) ? ~led : (led ^ (5'b00001 << ch));
            end else begin
              tog_n = tog + TW'(1);
            end
          end
        end
        if (state == RUN && i_stop) begin
          state_n = STOPPING;
        end
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_led_chase_sched.sv
// tb_led_chase_sched: directed, scoreboard-based bench for led_chase_sched.
// Bench parameters: HP0..HP4 = 4,3,2,2,1 and DWELL = 12. The bench derives
// expected outputs from a closed-form model indexed by clocks since start.
// The pause scenario runs only when LED_CHASE_SCHED_PAUSE_EN is defined.
module tb_led_chase_sched;

  localparam int unsigned DW = 12;
  localparam int HPT  [5] = '{4, 3, 2, 2, 1};
  localparam int PING [8] = '{0, 1, 2, 3, 4, 3, 2, 1};

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [1:0] mode;
  logic [4:0] led;
  logic [2:0] ch;
  logic       busy, sweep;
`ifdef LED_CHASE_SCHED_PAUSE_EN
  logic       pause;
`endif

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q[$];

  led_chase_sched #(
    .HP0(4), .HP1(3), .HP2(2), .HP3(2), .HP4(1), .DWELL(DW)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_stop  (stop),
`ifdef LED_CHASE_SCHED_PAUSE_EN
    .i_pause (pause),
`endif
    .i_mode  (mode),
    .o_led   (led),
    .o_ch    (ch),
    .o_busy  (busy),
    .o_sweep (sweep)
  );

  always #5 clk = ~clk;

  // Expected {led, ch, busy, sweep} k clocks after the start edge
  function automatic logic [9:0] model(input logic [1:0] m, input int k);
    int c, idx, pos;
    logic on, sw;
    logic [4:0] l;
    idx = k / DW;
    pos = k % DW;
    case (m)
      2'b00:   begin c = idx % 5;       sw = (k > 0) && (k % 60 == 0); end
      2'b01:   begin c = 4 - (idx % 5); sw = (k > 0) && (k % 60 == 0); end
      2'b10:   begin c = PING[idx % 8]; sw = (k > 0) && (k % 96 == 0); end
      default: begin c = 0;             sw = (k > 0) && (k % DW == 0); end
    endcase
    on = ((pos / HPT[c]) % 2) == 0;
    if (m == 2'b11) l = on ? 5'h1f : 5'h00;
    else            l = on ? (5'b00001 << c) : 5'h00;
    model = {l, 3'(c), 1'b1, sw};
  endfunction

  function automatic logic [9:0] idle_exp(input logic [2:0] c, input logic sw);
    idle_exp = {5'b0, c, 1'b0, sw};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag);
    logic [9:0] obs, e;
    obs = {led, ch, busy, sweep};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s: observed led=%b ch=%0d busy=%b sweep=%b, expected led=%b ch=%0d busy=%b sweep=%b",
               tag, obs[9:5], obs[4:2], obs[1], obs[0], e[9:5], e[4:2], e[1], e[0]);
      end
    end
  endtask

  task automatic expect_next(input logic [9:0] e, input string tag);
    exp_q.push_back(e);
    step();
    check(tag);
  endtask

  task automatic run_span(input logic [1:0] m, input int k0, input int k1, input string tag);
    for (int k = k0; k <= k1; k++) expect_next(model(m, k), tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;
`ifdef LED_CHASE_SCHED_PAUSE_EN
    pause = 1'b0;
`endif
    // Three reset clocks
    step(); step();
    expect_next(idle_exp(3'd0, 1'b0), "reset");
    rst = 1'b0;
    expect_next(idle_exp(3'd0, 1'b0), "idle_hold");

    // Forward chase; a mid-run start with a new mode must be ignored
    mode = 2'b00; start = 1'b1;
    expect_next(model(2'b00, 0), "fwd_start");
    start = 1'b0;
    run_span(2'b00, 1, 19, "fwd");
    start = 1'b1; mode = 2'b01;
    expect_next(model(2'b00, 20), "fwd_restart_ignored");
    start = 1'b0;
    run_span(2'b00, 21, 60, "fwd");
    rst = 1'b1;
    expect_next(idle_exp(3'd0, 1'b0), "fwd_reset");
    rst = 1'b0;

    // Ping-pong, one full sweep
    mode = 2'b10; start = 1'b1;
    expect_next(model(2'b10, 0), "ping_start");
    start = 1'b0;
    run_span(2'b10, 1, 96, "ping");
    rst = 1'b1;
    expect_next(idle_exp(3'd0, 1'b0), "ping_reset");
    rst = 1'b0;

    // Reverse with stop at clock 5 of channel 4 dwell
    mode = 2'b01; start = 1'b1;
    expect_next(model(2'b01, 0), "rev_start");
    start = 1'b0;
    run_span(2'b01, 1, 5, "rev");
    stop = 1'b1;
    expect_next(model(2'b01, 6), "rev_stopping");
    stop = 1'b0;
    run_span(2'b01, 7, 11, "rev_stopping");
    expect_next(idle_exp(3'd4, 1'b0), "rev_stop_idle");
    start = 1'b1; stop = 1'b1;
    expect_next(idle_exp(3'd4, 1'b0), "start_stop_idle");
    expect_next(idle_exp(3'd4, 1'b0), "start_stop_idle");
    start = 1'b0; stop = 1'b0;

    // Reverse again; stop in the last dwell still emits the sweep pulse
    mode = 2'b01; start = 1'b1;
    expect_next(model(2'b01, 0), "rev2_start");
    start = 1'b0;
    run_span(2'b01, 1, 50, "rev2");
    stop = 1'b1;
    expect_next(model(2'b01, 51), "rev2_stopping");
    run_span(2'b01, 52, 59, "rev2_stop_held");
    stop = 1'b0;
    expect_next(idle_exp(3'd0, 1'b1), "rev2_stop_sweep");
    expect_next(idle_exp(3'd0, 1'b0), "rev2_idle");

    // All-blink, reset at clock 30 aborts without a sweep pulse
    mode = 2'b11; start = 1'b1;
    expect_next(model(2'b11, 0), "all_start");
    start = 1'b0;
    run_span(2'b11, 1, 30, "all");
    rst = 1'b1;
    expect_next(idle_exp(3'd0, 1'b0), "all_reset");
    rst = 1'b0;
    expect_next(idle_exp(3'd0, 1'b0), "all_reset_idle");

`ifdef LED_CHASE_SCHED_PAUSE_EN
    // Pause for 7 clocks mid-dwell delays everything by exactly 7 clocks
    mode = 2'b00; start = 1'b1;
    expect_next(model(2'b00, 0), "pause_start");
    start = 1'b0;
    run_span(2'b00, 1, 5, "pre_pause");
    pause = 1'b1;
    for (int i = 0; i < 7; i++) expect_next(model(2'b00, 5), "paused");
    pause = 1'b0;
    run_span(2'b00, 6, 30, "post_pause");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
